// File: rtl/mcpu_mem_atom_resp.sv
// ============================================================================
// Module      : mcpu_mem_atom_resp
// Description : Atom-granular (256-bit) memory with per-byte write enables
//               and a fixed-latency pipelined read response. After reset the
//               controller zeroes one atom per cycle (INIT) while stalling
//               the requester, then serves requests (RUN).
//               Optional macro MCPU_MEM_ATOM_RESP_STALL_INJECT_EN adds an
//               LFSR-driven pseudo-random stall in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_mem_atom_resp #(
    parameter int DEPTH_ATOMS  = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic         clkrst_mem_clk,
    input  logic         clkrst_mem_rst_n,
    input  logic         arb2mem_valid,
    input  logic [2:0]   arb2mem_opcode,
    input  logic [31:5]  arb2mem_addr,
    input  logic [255:0] arb2mem_wdata,
    input  logic [31:0]  arb2mem_wbe,
    output logic         arb2mem_stall,
    output logic         arb2mem_rvalid,
    output logic [255:0] arb2mem_rdata
);

    localparam int         IDX_W    = $clog2(DEPTH_ATOMS);
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_ATOMS - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] init_cnt;
    logic             run_stall;
    logic             accept;
    logic             rd_acc;
    logic             wr_acc;
    logic [IDX_W-1:0] idx;
    logic             addr_unused;

    logic [255:0]            mem [DEPTH_ATOMS];
    logic [READ_LATENCY-1:0] pv;
    logic [255:0]            pd  [READ_LATENCY];

    // Upper address bits alias onto the same atoms; they are deliberately dropped.
    assign idx         = arb2mem_addr[IDX_W+4:5];
    assign addr_unused = ^arb2mem_addr[31:IDX_W+5];

    assign accept = arb2mem_valid & ~arb2mem_stall;
    assign rd_acc = accept & (arb2mem_opcode == OP_READ);
    assign wr_acc = accept & (arb2mem_opcode == OP_WRITE);

    // Controller state and init sweep counter
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + IDX_W'(1);
            end
        end
    end

    // Next-state and stall decode
    always_comb begin
        state_nxt     = state;
        arb2mem_stall = 1'b1;
        case (state)
            ST_INIT: begin
                if (init_cnt == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                arb2mem_stall = run_stall;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

`ifdef MCPU_MEM_ATOM_RESP_STALL_INJECT_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) stepping once per RUN cycle
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            lfsr <= 16'hACE1;
        end else if (state == ST_RUN) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign run_stall = (lfsr[1:0] == 2'b00);
`else
    assign run_stall = 1'b0;
`endif

    // Storage: zero sweep during INIT, byte-masked writes during RUN
    always_ff @(posedge clkrst_mem_clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < 32; b++) begin
                if (arb2mem_wbe[b]) begin
                    mem[idx][8*b +: 8] <= arb2mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the atom at accept; later stages only
    // load when a valid read passes, so the final stage holds its last data.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            pv <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) begin
                pd[0] <= mem[idx];
            end
            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign arb2mem_rvalid = pv[READ_LATENCY-1];
    assign arb2mem_rdata  = pd[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_mcpu_mem_atom_resp.sv
// ============================================================================
// Module      : tb_mcpu_mem_atom_resp
// Description : Directed self-checking bench for mcpu_mem_atom_resp
//               (DEPTH_ATOMS=64, READ_LATENCY=2, stall injection disabled).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_mem_atom_resp;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         valid  = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic [31:5]  addr   = '0;
    logic [255:0] wdata  = '0;
    logic [31:0]  wbe    = '0;
    logic         stall;
    logic         rvalid;
    logic [255:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [255:0] exp33;
    logic [255:0] dalias;

    mcpu_mem_atom_resp #(
        .DEPTH_ATOMS  (64),
        .READ_LATENCY (2)
    ) dut (
        .clkrst_mem_clk   (clk),
        .clkrst_mem_rst_n (rst_n),
        .arb2mem_valid    (valid),
        .arb2mem_opcode   (opcode),
        .arb2mem_addr     (addr),
        .arb2mem_wdata    (wdata),
        .arb2mem_wbe      (wbe),
        .arb2mem_stall    (stall),
        .arb2mem_rvalid   (rvalid),
        .arb2mem_rdata    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release reset at posedge+1 and check 64 stalled cycles then RUN;
    // a write is driven throughout INIT and must be ignored.
    task automatic init_seq();
        rst_n  = 1'b1;
        valid  = 1'b1;
        opcode = 3'b010;
        addr   = 27'd5;
        wdata  = {32{8'hFF}};
        wbe    = 32'hFFFF_FFFF;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            chk("init_stall", stall, 1'b1);
            chk("init_rvalid", rvalid, 1'b0);
            step();
        end
        valid  = 1'b0;
        opcode = 3'b000;
        @(negedge clk);
        chk("run_stall_c64", stall, 1'b0);
        step();
    endtask

    task automatic wr(input logic [26:0] a, input logic [255:0] d, input logic [31:0] be);
        valid  = 1'b1;
        opcode = 3'b010;
        addr   = a;
        wdata  = d;
        wbe    = be;
        @(negedge clk);
        chk("wr_stall", stall, 1'b0);
        step();
        valid  = 1'b0;
        opcode = 3'b000;
    endtask

    task automatic rd(input logic [26:0] a, input logic [255:0] exp, input string tag);
        valid  = 1'b1;
        opcode = 3'b001;
        addr   = a;
        @(negedge clk);
        chk({tag, "_stall"}, stall, 1'b0);
        step();
        valid  = 1'b0;
        opcode = 3'b000;
        @(negedge clk);
        chk({tag, "_early"}, rvalid, 1'b0);
        step();
        @(negedge clk);
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, exp);
        step();
        @(negedge clk);
        chk({tag, "_drop"}, rvalid, 1'b0);
        chk({tag, "_hold"}, rdata, exp);
        step();
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall", stall, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 256'd0);
        repeat (3) step();
        init_seq();

        // Zeroed atom read (write during INIT ignored)
        rd(27'd5, 256'd0, "rd5_zero");

        // Two masked writes then immediate read
        exp33          = '0;
        exp33[31:0]    = 32'hA5A5_A5A5;
        exp33[255:224] = 32'h3C3C_3C3C;
        wr(27'd3, {32{8'hA5}}, 32'h0000_000F);
        wr(27'd3, {32{8'h3C}}, 32'hF000_0000);
        rd(27'd3, exp33, "rd3_masked");

        // wbe=0 write changes nothing
        wr(27'd3, {32{8'hFF}}, 32'h0000_0000);
        rd(27'd3, exp33, "rd3_wbe0");

        // NOP codes: no rvalid, no state change
        valid  = 1'b1;
        opcode = 3'b000;
        addr   = 27'd3;
        wdata  = {32{8'hFF}};
        wbe    = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("nop_stall", stall, 1'b0);
        step();
        opcode = 3'b111;
        step();
        valid  = 1'b0;
        opcode = 3'b000;
        @(negedge clk);
        chk("nop_rvalid_a", rvalid, 1'b0);
        step();
        @(negedge clk);
        chk("nop_rvalid_b", rvalid, 1'b0);
        step();
        rd(27'd3, exp33, "rd3_after_nop");

        // Back-to-back reads return in order on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            wr(27'(i), 256'(i), 32'hFFFF_FFFF);
        end
        for (int k = 0; k < 6; k++) begin
            valid  = (k < 4);
            opcode = (k < 4) ? 3'b001 : 3'b000;
            addr   = 27'(k);
            @(negedge clk);
            if (k >= 2) begin
                chk("b2b_rvalid", rvalid, 1'b1);
                chk("b2b_rdata", rdata, 256'(k - 2));
            end else begin
                chk("b2b_early", rvalid, 1'b0);
            end
            step();
        end
        valid  = 1'b0;
        opcode = 3'b000;
        @(negedge clk);
        chk("b2b_end", rvalid, 1'b0);
        step();

        // Aliasing: addr 0x40 maps to atom 0
        dalias = {8{32'hDEAD_BEEF}};
        wr(27'h40, dalias, 32'hFFFF_FFFF);
        rd(27'd0, dalias, "alias");

        // Reset with two reads in flight
        valid  = 1'b1;
        opcode = 3'b001;
        addr   = 27'd1;
        step();
        addr   = 27'd2;
        step();
        valid  = 1'b0;
        opcode = 3'b000;
        chk("inflight_rvalid", rvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_stall", stall, 1'b1);
        chk("midrst_rdata", rdata, 256'd0);
        repeat (2) step();
        init_seq();
        rd(27'd1, 256'd0, "post_rst_rd1");
        rd(27'd0, 256'd0, "post_rst_rd0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcpu_mem_atom_resp.md
MCPU_MEM_ATOM_RESP -- requirements
Module: MCPU_MEM_atom_resp

Interface
REQ-001 SHALL provide parameter DEPTH_ATOMS, default 64, number of 256-bit atoms stored; power of two, 2..1024.
REQ-002 SHALL provide parameter READ_LATENCY, default 2, cycles from read acceptance to rvalid; legal range 1..4.
REQ-003 SHALL provide port clkrst_mem_clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL provide port clkrst_mem_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port arb2mem_valid  input  1  request present.
REQ-006 SHALL provide port arb2mem_opcode  input  3  3'b001 READ, 3'b010 WRITE, all other codes NOP.
REQ-007 SHALL provide port arb2mem_addr  input  27 ([31:5])  atom address.
REQ-008 SHALL provide port arb2mem_wdata  input  256  write data; byte i on bits [8i+7:8i].
REQ-009 SHALL provide port arb2mem_wbe  input  32  per-byte write enable.
REQ-010 SHALL provide port arb2mem_stall  output  1  request not accepted this cycle.
REQ-011 SHALL provide port arb2mem_rvalid  output  1  single-cycle read-data strobe.
REQ-012 SHALL provide port arb2mem_rdata  output  256  read data, qualified by rvalid.

Function
REQ-013 Request SHALL be accepted in a cycle iff arb2mem_valid=1 and arb2mem_stall=0; at most one per cycle.
REQ-014 Atom index SHALL be arb2mem_addr[5+log2(DEPTH_ATOMS)-1:5]; upper address bits ignored (aliasing, wrap-around).
REQ-015 Accepted WRITE SHALL update exactly the bytes whose wbe bit is 1 at the clock edge ending the accept cycle; wbe=0 SHALL leave the atom unchanged and produce no response.
REQ-016 Accepted READ in cycle N SHALL assert arb2mem_rvalid for exactly cycle N+READ_LATENCY with the atom contents as of the end of cycle N.
REQ-017 READ accepted in the cycle after a WRITE to the same index SHALL return the written data.
REQ-018 Reads SHALL be pipelined: back-to-back READs every cycle SHALL produce back-to-back rvalid in acceptance order.
REQ-019 NOP codes SHALL be accepted when not stalled and SHALL cause no state change and no rvalid.
REQ-020 WRITEs SHALL produce no rvalid.
REQ-021 arb2mem_rdata SHALL hold its last value when rvalid=0.
REQ-022 Controller SHALL have two states: INIT and RUN.
REQ-023 INIT: zero one atom per cycle, index 0 to DEPTH_ATOMS-1, with arb2mem_stall=1 throughout; after the last atom, go to RUN.
REQ-024 INIT SHALL last exactly DEPTH_ATOMS cycles after reset deassertion; first possible accept is in cycle DEPTH_ATOMS.
REQ-025 RUN: arb2mem_stall=0 except as set by REQ-030; RUN SHALL be left only by reset.
REQ-026 The valid/opcode/addr/wdata/wbe inputs SHALL be ignored while stall=1; the requester need not hold them.

Reset
REQ-027 On rst_n low, outputs SHALL immediately be: stall=1, rvalid=0, rdata=0; state INIT, init counter 0.
REQ-028 Reads in flight at reset SHALL be discarded; no rvalid SHALL appear for them after reset release.
REQ-029 Reset mid-INIT or mid-RUN SHALL restart INIT from index 0.

Configuration
REQ-030 Macro MCPU_MEM_ATOM_RESP_STALL_INJECT_EN defined: in RUN, add a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1; advances every RUN cycle); arb2mem_stall=1 when lfsr[1:0]==2'b00; rvalid timing for accepted reads is unaffected.
REQ-031 Macro not defined: no LFSR logic; arb2mem_stall=0 in every RUN cycle.

Verification
REQ-032 Reset release, DEPTH_ATOMS=64 -> stall=1 for cycles 0..63, 0 at cycle 64; READ of addr 5 -> rdata=0, rvalid at accept+2.
REQ-033 WRITE addr 3, wdata all 8'hA5, wbe=32'h0000000F; then WRITE addr 3, wdata all 8'h3C, wbe=32'hF0000000; next cycle READ addr 3 -> bytes 0-3=A5, bytes 28-31=3C, others 00.
REQ-034 READ addrs 0,1,2,3 on consecutive cycles after writing value i to each -> four consecutive rvalid cycles carrying 0,1,2,3 in order.
REQ-035 WRITE addr 27'h40 (DEPTH 64), then READ addr 0 -> returns the addr-0x40 data (aliasing).
REQ-036 Two READs in flight, assert rst_n low -> rvalid drops same cycle, no rvalid after release, stall=1 for 64 cycles.
REQ-037 With MCPU_MEM_ATOM_RESP_STALL_INJECT_EN, 1000 random requests -> stall pattern matches reference LFSR model from seed 16'hACE1; every accepted READ answered exactly READ_LATENCY cycles later.
